// File: rtl/pkt_fifo_arbiter.sv
// pkt_fifo_arbiter
//   Packet-granular round-robin merge of NUM_PORTS Avalon-ST streams into one
//   packet FIFO that signals backpressure through almost_full only.
//   A port holds the grant from its SOP beat through its EOP beat, so packets
//   never interleave. Beats without SOP presented while idle are drained and
//   flagged. Statistics counters feed the CSR block.
//
// Ports
//   in_clk, rst_l           clock, asynchronous active-low reset
//   in_data/in_valid/in_ready/in_startofpacket/in_endofpacket/in_empty
//                           per-port Avalon-ST sinks (port i in slice i)
//   out_data/out_valid/out_startofpacket/out_endofpacket/out_empty
//                           registered FIFO write side (no ready)
//   fifo_almost_full        FIFO backpressure, only consulted when granting
//   grant_valid             a packet is in flight
//   grant_port              current or most recent granted port
//   protocol_err            sticky: a stray non-SOP beat was drained
//   pkt_count               packets forwarded (wraps)
//   stall_cycles            grant attempts blocked by almost_full (saturates)

// Per-port ready/request cell.
module pkt_fifo_arbiter_lane (
    input  logic valid,
    input  logic sop,
    input  logic locked,
    input  logic selected,
    output logic ready,
    output logic req,
    output logic stray
);
    assign req   = valid & sop;
    assign stray = ~locked & valid & ~sop;
    // While locked only the owner is ready; while idle, stray beats are
    // accepted so they drain instead of wedging the port.
    assign ready = locked ? selected : (valid & ~sop);
endmodule

module pkt_fifo_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 512,
    parameter int EMPTY_W   = 6,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                           in_clk,
    input  logic                           rst_l,
    input  logic [NUM_PORTS*DATA_W-1:0]    in_data,
    input  logic [NUM_PORTS-1:0]           in_valid,
    output logic [NUM_PORTS-1:0]           in_ready,
    input  logic [NUM_PORTS-1:0]           in_startofpacket,
    input  logic [NUM_PORTS-1:0]           in_endofpacket,
    input  logic [NUM_PORTS*EMPTY_W-1:0]   in_empty,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_valid,
    output logic                           out_startofpacket,
    output logic                           out_endofpacket,
    output logic [EMPTY_W-1:0]             out_empty,
    input  logic                           fifo_almost_full,
    output logic                           grant_valid,
    output logic [PORT_W-1:0]              grant_port,
    output logic                           protocol_err,
    output logic [31:0]                    pkt_count,
    output logic [31:0]                    stall_cycles
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t state, state_nxt;

    logic [NUM_PORTS-1:0][DATA_W-1:0]  data_arr;
    logic [NUM_PORTS-1:0][EMPTY_W-1:0] empty_arr;
    logic [NUM_PORTS-1:0]              req;
    logic [NUM_PORTS-1:0]              stray;
    logic [PORT_W-1:0]                 pick;
    logic                              grant_load;
    logic                              stall;
    logic                              accept;
    logic                              accept_eop;

    assign data_arr  = in_data;
    assign empty_arr = in_empty;

    genvar i;
    generate
        for (i = 0; i < NUM_PORTS; i++) begin : g_lane
            pkt_fifo_arbiter_lane u_lane (
                .valid    (in_valid[i]),
                .sop      (in_startofpacket[i]),
                .locked   (state == LOCK),
                .selected (grant_port == PORT_W'(i)),
                .ready    (in_ready[i]),
                .req      (req[i]),
                .stray    (stray[i])
            );
        end
    endgenerate

    // grant_port doubles as last_grant: both load the same index on every
    // grant and reset to NUM_PORTS-1, so port 0 wins the first search.
    always_comb begin
        int idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        pick  = grant_port;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(grant_port) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PORT_W'(idx);
            end
        end
    end

    // Stray beats are never forwarded: acceptance into the output register
    // only happens while locked, even if the idle owner index has a stray.
    assign accept     = (state == LOCK) && in_valid[grant_port];
    assign accept_eop = accept && in_endofpacket[grant_port];

    always_ff @(posedge in_clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_load = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    if (!fifo_almost_full) begin
                        state_nxt  = LOCK;
                        grant_load = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            LOCK: begin
                // almost_full is ignored here; FIFO headroom covers a full packet.
                if (accept_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_valid = (state == LOCK);

    always_ff @(posedge in_clk or negedge rst_l) begin
        if (!rst_l) begin
            out_data          <= '0;
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= '0;
            grant_port        <= PORT_W'(NUM_PORTS - 1);
            protocol_err      <= 1'b0;
            pkt_count         <= '0;
            stall_cycles      <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_data          <= data_arr[grant_port];
                out_startofpacket <= in_startofpacket[grant_port];
                out_endofpacket   <= in_endofpacket[grant_port];
                out_empty         <= empty_arr[grant_port];
            end
            if (grant_load) grant_port <= pick;
            if (accept_eop) pkt_count <= pkt_count + 32'd1;
            if (stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (|stray) protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pkt_fifo_arbiter.sv
module tb_pkt_fifo_arbiter;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int EW = 6;
    localparam int PW = 2;

    logic                 in_clk = 1'b0;
    logic                 rst_l  = 1'b1;
    logic [NP-1:0][DW-1:0] d;
    logic [NP-1:0][EW-1:0] em;
    logic [NP-1:0]        v, s, e;
    logic [NP-1:0]        in_ready;
    logic                 af;
    logic [DW-1:0]        out_data;
    logic                 out_valid, out_startofpacket, out_endofpacket;
    logic [EW-1:0]        out_empty;
    logic                 grant_valid;
    logic [PW-1:0]        grant_port;
    logic                 protocol_err;
    logic [31:0]          pkt_count, stall_cycles;

    int passed = 0;
    int total  = 0;

    pkt_fifo_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .EMPTY_W(EW)) dut (
        .in_clk            (in_clk),
        .rst_l             (rst_l),
        .in_data           (d),
        .in_valid          (v),
        .in_ready          (in_ready),
        .in_startofpacket  (s),
        .in_endofpacket    (e),
        .in_empty          (em),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .fifo_almost_full  (af),
        .grant_valid       (grant_valid),
        .grant_port        (grant_port),
        .protocol_err      (protocol_err),
        .pkt_count         (pkt_count),
        .stall_cycles      (stall_cycles)
    );

    always #5 in_clk = ~in_clk;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic clear_inputs();
        v = '0; s = '0; e = '0; d = '0; em = '0; af = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_l = 1'b0;
        #1;
        repeat (2) tick();
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_l = 1'b1;
        #1;
        rst_l = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_startofpacket !== 1'b0 || out_endofpacket !== 1'b0 ||
            out_data !== '0 || out_empty !== '0)
            $display("FAIL rst_out: got v=%b sop=%b eop=%b data=%h empty=%0d, want all 0",
                     out_valid, out_startofpacket, out_endofpacket, out_data, out_empty);
        else passed++;
        total++;
        if (grant_valid !== 1'b0 || grant_port !== 2'd3)
            $display("FAIL rst_grant: got gv=%b gp=%0d, want gv=0 gp=3", grant_valid, grant_port);
        else passed++;
        total++;
        if (protocol_err !== 1'b0 || pkt_count !== 32'd0 || stall_cycles !== 32'd0)
            $display("FAIL rst_stats: got perr=%b pkt=%0d stall=%0d, want 0/0/0",
                     protocol_err, pkt_count, stall_cycles);
        else passed++;
        total++;
        if (in_ready !== 4'b0000)
            $display("FAIL rst_ready: got %b want 0000", in_ready);
        else passed++;
        repeat (2) tick();
        rst_l = 1'b1;
    endtask

    task automatic test_single_port();
        do_reset();
        v[2] = 1'b1; s[2] = 1'b1; e[2] = 1'b0; d[2] = 32'hA0; em[2] = '0;
        #1;
        total++;
        if (in_ready !== 4'b0000)
            $display("FAIL sp_ready_idle: got %b want 0000", in_ready);
        else passed++;
        tick();
        total++;
        if (grant_valid !== 1'b1 || grant_port !== 2'd2 || out_valid !== 1'b0)
            $display("FAIL sp_grant: got gv=%b gp=%0d ov=%b, want 1/2/0",
                     grant_valid, grant_port, out_valid);
        else passed++;
        for (int b = 0; b < 4; b++) begin
            #1;
            total++;
            if (in_ready !== 4'b0100)
                $display("FAIL sp_ready_lock beat %0d: got %b want 0100", b, in_ready);
            else passed++;
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'hA0 + 32'(b) ||
                out_startofpacket !== (b == 0) || out_endofpacket !== (b == 3) ||
                out_empty !== ((b == 3) ? 6'd5 : 6'd0))
                $display("FAIL sp_beat %0d: got v=%b d=%h sop=%b eop=%b emp=%0d, want 1 %h %b %b %0d",
                         b, out_valid, out_data, out_startofpacket, out_endofpacket, out_empty,
                         32'hA0 + 32'(b), (b == 0), (b == 3), (b == 3) ? 5 : 0);
            else passed++;
            if (b < 3) begin
                d[2] = 32'hA0 + 32'(b + 1); s[2] = 1'b0;
                e[2] = (b + 1 == 3); em[2] = (b + 1 == 3) ? 6'd5 : 6'd0;
            end else begin
                v[2] = 1'b0; e[2] = 1'b0;
            end
        end
        total++;
        if (pkt_count !== 32'd1 || grant_valid !== 1'b0 || grant_port !== 2'd2)
            $display("FAIL sp_done: got pkt=%0d gv=%b gp=%0d, want 1/0/2",
                     pkt_count, grant_valid, grant_port);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'hA3 || out_endofpacket !== 1'b1)
            $display("FAIL sp_hold: got v=%b d=%h eop=%b, want 0 a3 1",
                     out_valid, out_data, out_endofpacket);
        else passed++;
    endtask

    task automatic test_round_robin();
        int bc[NP];
        int np[NP];
        int nb;
        int cyc;
        logic [NP-1:0] acc;
        int pk, p, n, b;
        do_reset();
        for (int i = 0; i < NP; i++) begin bc[i] = 0; np[i] = 0; end
        nb = 0; cyc = 0;
        while (cyc < 60 && nb < 10) begin
            for (int i = 0; i < NP; i++) begin
                v[i] = 1'b1; s[i] = (bc[i] == 0); e[i] = (bc[i] == 1);
                d[i] = 32'(i * 256 + np[i] * 16 + bc[i]);
            end
            #1;
            acc = v & in_ready;
            tick();
            for (int i = 0; i < NP; i++) begin
                if (acc[i]) begin
                    if (bc[i] == 1) begin bc[i] = 0; np[i]++; end
                    else bc[i] = 1;
                end
            end
            if (out_valid) begin
                pk = nb / 2; p = pk % NP; n = pk / NP; b = nb % 2;
                total++;
                if (out_data !== 32'(p * 256 + n * 16 + b) ||
                    out_startofpacket !== (b == 0) || out_endofpacket !== (b == 1))
                    $display("FAIL rr_beat %0d: got d=%h sop=%b eop=%b, want d=%h sop=%b eop=%b",
                             nb, out_data, out_startofpacket, out_endofpacket,
                             32'(p * 256 + n * 16 + b), (b == 0), (b == 1));
                else passed++;
                nb++;
            end
            cyc++;
        end
        total++;
        if (nb != 10 || pkt_count !== 32'd5)
            $display("FAIL rr_count: got beats=%0d pkt=%0d, want 10/5", nb, pkt_count);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_af_block();
        logic any_rdy;
        do_reset();
        af = 1'b1;
        v[1] = 1'b1; s[1] = 1'b1; e[1] = 1'b1; d[1] = 32'hB0; em[1] = 6'd3;
        any_rdy = 1'b0;
        repeat (10) begin
            #1;
            any_rdy = any_rdy | (|in_ready);
            tick();
        end
        total++;
        if (any_rdy !== 1'b0 || stall_cycles !== 32'd10 || grant_valid !== 1'b0)
            $display("FAIL af_block: got rdy_seen=%b stall=%0d gv=%b, want 0/10/0",
                     any_rdy, stall_cycles, grant_valid);
        else passed++;
        af = 1'b0;
        tick();
        total++;
        if (grant_valid !== 1'b1 || grant_port !== 2'd1 || stall_cycles !== 32'd10)
            $display("FAIL af_grant: got gv=%b gp=%0d stall=%0d, want 1/1/10",
                     grant_valid, grant_port, stall_cycles);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hB0 || out_startofpacket !== 1'b1 ||
            out_endofpacket !== 1'b1 || out_empty !== 6'd3 || pkt_count !== 32'd1)
            $display("FAIL af_beat: got v=%b d=%h sop=%b eop=%b emp=%0d pkt=%0d, want 1 b0 1 1 3 1",
                     out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, pkt_count);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_af_midpacket();
        do_reset();
        v[0] = 1'b1; s[0] = 1'b1; e[0] = 1'b0; d[0] = 32'hC0;
        v[2] = 1'b1; s[2] = 1'b1; e[2] = 1'b1; d[2] = 32'hE0;
        tick();
        total++;
        if (grant_valid !== 1'b1 || grant_port !== 2'd0)
            $display("FAIL afm_grant: got gv=%b gp=%0d, want 1/0", grant_valid, grant_port);
        else passed++;
        for (int b = 0; b < 8; b++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'hC0 + 32'(b) || out_endofpacket !== (b == 7))
                $display("FAIL afm_beat %0d: got v=%b d=%h eop=%b, want 1 %h %b",
                         b, out_valid, out_data, out_endofpacket, 32'hC0 + 32'(b), (b == 7));
            else passed++;
            if (b < 7) begin
                d[0] = 32'hC0 + 32'(b + 1); s[0] = 1'b0; e[0] = (b + 1 == 7);
                if (b + 1 == 2) af = 1'b1;
            end else begin
                v[0] = 1'b0; e[0] = 1'b0;
            end
        end
        total++;
        if (pkt_count !== 32'd1)
            $display("FAIL afm_pkt: got %0d want 1", pkt_count);
        else passed++;
        repeat (3) tick();
        total++;
        if (grant_valid !== 1'b0 || stall_cycles !== 32'd3 || out_valid !== 1'b0)
            $display("FAIL afm_held: got gv=%b stall=%0d ov=%b, want 0/3/0",
                     grant_valid, stall_cycles, out_valid);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_stray();
        do_reset();
        v[3] = 1'b1; s[3] = 1'b0; d[3] = 32'hDEAD;
        #1;
        total++;
        if (in_ready !== 4'b1000)
            $display("FAIL stray_ready: got %b want 1000", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || protocol_err !== 1'b1 || grant_valid !== 1'b0)
            $display("FAIL stray_drop: got ov=%b perr=%b gv=%b, want 0/1/0",
                     out_valid, protocol_err, grant_valid);
        else passed++;
        v[3] = 1'b0;
        repeat (3) tick();
        total++;
        if (protocol_err !== 1'b1 || out_valid !== 1'b0 || pkt_count !== 32'd0)
            $display("FAIL stray_sticky: got perr=%b ov=%b pkt=%0d, want 1/0/0",
                     protocol_err, out_valid, pkt_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        v[1] = 1'b1; s[1] = 1'b0;
        tick();
        v[1] = 1'b0;
        v[0] = 1'b1; s[0] = 1'b1; e[0] = 1'b0; d[0] = 32'hF0;
        tick();
        tick();
        d[0] = 32'hF1; s[0] = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hF1 || protocol_err !== 1'b1)
            $display("FAIL rm_pre: got ov=%b d=%h perr=%b, want 1 f1 1",
                     out_valid, out_data, protocol_err);
        else passed++;
        d[0] = 32'hF2;
        #1;
        rst_l = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_startofpacket !== 1'b0 ||
            out_endofpacket !== 1'b0 || grant_valid !== 1'b0)
            $display("FAIL rm_out: got ov=%b d=%h sop=%b eop=%b gv=%b, want all 0",
                     out_valid, out_data, out_startofpacket, out_endofpacket, grant_valid);
        else passed++;
        total++;
        if (protocol_err !== 1'b0 || pkt_count !== 32'd0 || grant_port !== 2'd3)
            $display("FAIL rm_state: got perr=%b pkt=%0d gp=%0d, want 0/0/3",
                     protocol_err, pkt_count, grant_port);
        else passed++;
        clear_inputs();
        tick();
        rst_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b1; s[i] = 1'b1; e[i] = 1'b1; d[i] = 32'h100 + 32'(i);
        end
        tick();
        total++;
        if (grant_valid !== 1'b1 || grant_port !== 2'd0)
            $display("FAIL rm_first_grant: got gv=%b gp=%0d, want 1/0", grant_valid, grant_port);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h100 || pkt_count !== 32'd1)
            $display("FAIL rm_first_pkt: got ov=%b d=%h pkt=%0d, want 1 100 1",
                     out_valid, out_data, pkt_count);
        else passed++;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_port();
        test_round_robin();
        test_af_block();
        test_af_midpacket();
        test_stray();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", passed, total);
        $fatal(1);
    end
endmodule
